// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared widths, mode codes and carry-save helper for mul32_pipelined
//
// Purpose: constants and the row-level 3:2 compression step used by the
//          multiplier reduction tree.
// Ports:   none (package)
package mul_pkg;

   localparam int XLEN  = 32;
   localparam int PLEN  = 64;
   localparam int NROWS = XLEN + 1;   // one partial-product row per extended multiplier bit

   localparam logic [1:0] MODE_UU = 2'b00;
   localparam logic [1:0] MODE_SS = 2'b01;
   localparam logic [1:0] MODE_SU = 2'b10;

   // Dadda height schedule of the reduction tree (rows remaining after each level)
   localparam int H0 = 33;
   localparam int H1 = 28;
   localparam int H2 = 19;
   localparam int H3 = 13;
   localparam int H4 = 9;
   localparam int H5 = 6;
   localparam int H6 = 4;
   localparam int H7 = 3;
   localparam int H8 = 2;

   // widest single level is 28 -> 19
   localparam int MAX_CSA = 9;

   typedef logic [NROWS-1:0][PLEN-1:0] rows_t;

   // One reduction level: the first (n_in - n_out) triples of rows go through
   // full-adder rows (sum row + carry row shifted up one column), the rest pass
   // straight through. Carries out of column 63 are dropped because only the
   // low 64 product bits are kept.
   function automatic rows_t csa_level(input rows_t r, input int n_in, input int n_out);
      rows_t o;
      int    n_csa;
      o     = '0;
      n_csa = n_in - n_out;
      for (int k = 0; k < MAX_CSA; k++) begin
         if (k < n_csa) begin
            o[2*k]   = r[3*k] ^ r[3*k+1] ^ r[3*k+2];
            o[2*k+1] = ((r[3*k] & r[3*k+1]) | (r[3*k] & r[3*k+2]) | (r[3*k+1] & r[3*k+2])) << 1;
         end
      end
      for (int i = 0; i < NROWS; i++) begin
         if (i >= 3*n_csa && i < n_in) begin
            o[i-n_csa] = r[i];
         end
      end
      return o;
   endfunction

endpackage

// File: rtl/mul32_pipelined_delay_line.sv
// rtl/mul32_pipelined_delay_line.sv - W-bit, L-deep register chain with async active-low clear
//
// Purpose: aligns operand/mode side data with pipeline stages.
// Ports:   clk   - clock, rising edge
//          rst_n - asynchronous active-low clear of every stage
//          din   - W-bit data entering the chain
//          dout  - din delayed by L clocks
module delay_line #(
   parameter int W = 8,
   parameter int L = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [L-1:0][W-1:0] chain_q;
   logic [L-1:0][W-1:0] chain_d;

   always_comb begin
      chain_d    = '0;
      chain_d[0] = din;
      for (int i = 1; i < L; i++) begin
         chain_d[i] = chain_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

   assign dout = chain_q[L-1];

endmodule

// File: rtl/mul32_pipelined.sv
// rtl/mul32_pipelined.sv - 32x32->64 eight-stage pipelined Dadda-tree multiplier
//
// Purpose: multiplies a by b with per-operation signedness, one op per clock,
//          result {hi,lo} valid 8 register stages after the inputs are taken.
// Ports:   clk   - clock, rising edge
//          rst_n - asynchronous active-low reset, clears the whole pipe
//          a     - multiplicand
//          b     - multiplier
//          mode  - 00 uu, 01 ss, 10 a signed / b unsigned, 11 same as 00
//          lo    - product[31:0]
//          hi    - product[63:32]
module mul32_pipelined
   import mul_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [1:0]      mode,
   output logic [XLEN-1:0] lo,
   output logic [XLEN-1:0] hi
);

   // stage 1: input register; mode rides with its operands
   logic [2+2*XLEN-1:0] in_q;

   delay_line #(.W(2 + 2*XLEN), .L(1)) u_in_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .din   ({mode, a, b}),
      .dout  (in_q)
   );

   logic [1:0]      s1_mode;
   logic [XLEN-1:0] s1_a;
   logic [XLEN-1:0] s1_b;
   assign {s1_mode, s1_a, s1_b} = in_q;

   logic [XLEN:0] x_ext;
   logic [XLEN:0] y_ext;
   rows_t         pp;
   rows_t         t2, t3, t4, t5, t6;

   logic [H1-1:0][PLEN-1:0] rows28_q, rows28_d;
   logic [H3-1:0][PLEN-1:0] rows13_q, rows13_d;
   logic [H5-1:0][PLEN-1:0] rows6_q,  rows6_d;
   logic [H7-1:0][PLEN-1:0] rows3_q,  rows3_d;
   logic [H8-1:0][PLEN-1:0] rows2_q,  rows2_d;

   logic [XLEN:0]   sum_lo;
   logic [XLEN-1:0] lo7_q, lo7_d;
   logic            c7_q, c7_d;
   logic [XLEN-1:0] hia7_q, hia7_d;
   logic [XLEN-1:0] hib7_q, hib7_d;
   logic [XLEN-1:0] lo_out_q, lo_out_d;
   logic [XLEN-1:0] hi_out_q, hi_out_d;

   // stage 2: 33-bit operand extension, Baugh-Wooley partial products, first level
   always_comb begin
      x_ext = {((s1_mode == MODE_SS) || (s1_mode == MODE_SU)) ? s1_a[XLEN-1] : 1'b0, s1_a};
      y_ext = {(s1_mode == MODE_SS) ? s1_b[XLEN-1] : 1'b0, s1_b};
      pp    = '0;
      // rows 0..31: plain AND terms with the sign-bit cross term inverted
      for (int j = 0; j < XLEN; j++) begin
         pp[j] = {31'b0, ~(x_ext[XLEN] & y_ext[j]), x_ext[XLEN-1:0] & {XLEN{y_ext[j]}}} << j;
      end
      // row 32: inverted cross terms; the x32*y32 term lands at bit 64 and is dropped
      pp[XLEN] = {~(x_ext[XLEN-1:0] & {XLEN{y_ext[XLEN]}}), {XLEN{1'b0}}};
      // correction constant 2^33 (+2^65, which falls outside 64 bits); bit 33 of row 0 is free
      pp[0][XLEN+1] = 1'b1;
      t2       = csa_level(pp, H0, H1);
      rows28_d = t2[H1-1:0];
   end

   // stage 3: 28 -> 19 -> 13
   always_comb begin
      t3          = '0;
      t3[H1-1:0]  = rows28_q;
      t3          = csa_level(t3, H1, H2);
      t3          = csa_level(t3, H2, H3);
      rows13_d    = t3[H3-1:0];
   end

   // stage 4: 13 -> 9 -> 6
   always_comb begin
      t4          = '0;
      t4[H3-1:0]  = rows13_q;
      t4          = csa_level(t4, H3, H4);
      t4          = csa_level(t4, H4, H5);
      rows6_d     = t4[H5-1:0];
   end

   // stage 5: 6 -> 4 -> 3
   always_comb begin
      t5          = '0;
      t5[H5-1:0]  = rows6_q;
      t5          = csa_level(t5, H5, H6);
      t5          = csa_level(t5, H6, H7);
      rows3_d     = t5[H7-1:0];
   end

   // stage 6: 3 -> 2
   always_comb begin
      t6          = '0;
      t6[H7-1:0]  = rows3_q;
      t6          = csa_level(t6, H7, H8);
      rows2_d     = t6[H8-1:0];
   end

   // stages 7-8: carry-propagate add split at bit 32; carry crosses in a flop
   always_comb begin
      sum_lo   = {1'b0, rows2_q[0][XLEN-1:0]} + {1'b0, rows2_q[1][XLEN-1:0]};
      lo7_d    = sum_lo[XLEN-1:0];
      c7_d     = sum_lo[XLEN];
      hia7_d   = rows2_q[0][PLEN-1:XLEN];
      hib7_d   = rows2_q[1][PLEN-1:XLEN];
      lo_out_d = lo7_q;
      hi_out_d = hia7_q + hib7_q + {{(XLEN-1){1'b0}}, c7_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rows28_q <= '0;
         rows13_q <= '0;
         rows6_q  <= '0;
         rows3_q  <= '0;
         rows2_q  <= '0;
         lo7_q    <= '0;
         c7_q     <= 1'b0;
         hia7_q   <= '0;
         hib7_q   <= '0;
         lo_out_q <= '0;
         hi_out_q <= '0;
      end else begin
         rows28_q <= rows28_d;
         rows13_q <= rows13_d;
         rows6_q  <= rows6_d;
         rows3_q  <= rows3_d;
         rows2_q  <= rows2_d;
         lo7_q    <= lo7_d;
         c7_q     <= c7_d;
         hia7_q   <= hia7_d;
         hib7_q   <= hib7_d;
         lo_out_q <= lo_out_d;
         hi_out_q <= hi_out_d;
      end
   end

   assign lo = lo_out_q;
   assign hi = hi_out_q;

endmodule

// File: tb/tb_mul32_pipelined.sv
// tb/tb_mul32_pipelined.sv - self-checking bench for mul32_pipelined
module tb_mul32_pipelined;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic [1:0]  mode_in;
   logic [31:0] lo;
   logic [31:0] hi;
   logic [65:0] gold;

   int cyc        = 0;
   int n_vec      = 0;
   int n_err      = 0;
   int zero_until = 0;

   int          due_q[$];
   logic [63:0] exp_q[$];
   string       tag_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mul32_pipelined dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a_in),
      .b     (b_in),
      .mode  (mode_in),
      .lo    (lo),
      .hi    (hi)
   );

   delay_line #(.W(66), .L(8)) u_gold (
      .clk   (clk),
      .rst_n (rst_n),
      .din   ({mode_in, a_in, b_in}),
      .dout  (gold)
   );

   function automatic logic [63:0] ref_prod(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy;
      sx = (m == 2'b01 || m == 2'b10) ? longint'($signed(x)) : longint'({32'b0, x});
      sy = (m == 2'b01) ? longint'($signed(y)) : longint'({32'b0, y});
      return 64'(sx * sy);
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic compare_all();
      check("golden", {hi, lo}, ref_prod(gold[65:64], gold[63:32], gold[31:0]));
      if (cyc < zero_until) check("post_rst_zero", {hi, lo}, 64'd0);
      while (due_q.size() > 0 && due_q[0] <= cyc) begin
         check(tag_q[0], {hi, lo}, exp_q[0]);
         void'(due_q.pop_front());
         void'(exp_q.pop_front());
         void'(tag_q.pop_front());
      end
   endtask

   task automatic step(input logic [1:0] m, input logic [31:0] x, input logic [31:0] y,
                       input bit dir, input logic [63:0] e, input string tag);
      @(negedge clk);
      compare_all();
      mode_in = m;
      a_in    = x;
      b_in    = y;
      if (dir) begin
         due_q.push_back(cyc + 8);
         exp_q.push_back(e);
         tag_q.push_back(tag);
      end
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic basic_ops(input string pfx);
      step(2'b00, 32'd292, 32'd6785, 1, 64'd1981220, {pfx, "t1_uu"});
      step(2'b01, 32'(-12345678), 32'd87654321, 1, 64'(-64'sd1082152022374638), {pfx, "t2_ss"});
      step(2'b10, 32'(-20000000), 32'(-30000000), 1, 64'(-64'sd85299345920000000), {pfx, "t3_su"});
   endtask

   initial begin
      rst_n   = 1'b0;
      a_in    = '0;
      b_in    = '0;
      mode_in = '0;
      repeat (3) @(negedge clk);
      check("reset_state", {hi, lo}, 64'd0);
      rst_n      = 1'b1;
      zero_until = cyc + 8;

      basic_ops("");

      // corners back to back, modes alternating
      step(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFE_0000_0001, "c_uu_max");
      step(2'b01, 32'h8000_0000, 32'h8000_0000, 1, 64'h4000_0000_0000_0000, "c_ss_min");
      step(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 64'h8000_0000_8000_0000, "c_su_min");
      step(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'd1,                   "c_ss_m1");
      step(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFE_0000_0001, "c_m11_max");
      step(2'b01, 32'h0000_0000, 32'h8000_0000, 1, 64'd0,                   "c_ss_zero");
      step(2'b10, 32'h8000_0000, 32'h0000_0000, 1, 64'd0,                   "c_su_zero");
      step(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 1, 64'h0000_0001_FFFF_FFFE, "c_uu_x2");
      step(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 1, 64'hFFFF_FFFF_FFFF_FFFE, "c_ss_neg");
      repeat (9) step(2'b00, 32'd0, 32'd0, 0, 64'd0, "");

      // reset with ops in flight
      for (int i = 0; i < 10; i++) begin
         step(2'(i % 3), 32'h1234_0000 + 32'(i), 32'h0000_5678 + 32'(7*i), 0, 64'd0, "");
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("rst_async", {hi, lo}, 64'd0);
      due_q.delete();
      exp_q.delete();
      tag_q.delete();
      @(negedge clk);
      check("rst_hold", {hi, lo}, 64'd0);
      @(negedge clk);
      check("rst_hold", {hi, lo}, 64'd0);
      rst_n      = 1'b1;
      zero_until = cyc + 8;

      basic_ops("pr_");

      for (int i = 0; i < 10000; i++) begin
         step(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), 0, 64'd0, "");
      end
      repeat (9) step(2'b00, 32'd0, 32'd0, 0, 64'd0, "");

      if (due_q.size() != 0) check("pending_directed", 64'(due_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
